mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_req_slot.sv | 45 ++++
 rtl/mem_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int NUM_REQ = 2;
  localparam int REQ_I   = 0;
  localparam int REQ_D   = 1;

endpackage

// File: rtl/mem_arbiter_req_slot.sv
// One-entry request holding register: captures a request pulse, clears on
// completion, and exposes the post-edge contents so a grant can bypass it.
module req_slot
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     pulse,
  input  mem_req_t pulse_req,
  input  logic     clr,
  output logic     nxt_full,
  output mem_req_t nxt_req,
  output logic     drop
);

  logic     full;
  mem_req_t req;

  // A pulse landing on the completion edge refills the freed entry.
  assign drop = pulse && full && !clr;

  always_comb begin
    nxt_full = full;
    nxt_req  = req;
    if (clr) begin
      nxt_full = 1'b0;
      nxt_req  = '0;
    end
    if (pulse && !drop) begin
      nxt_full = 1'b1;
      nxt_req  = pulse_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      req  <= '0;
    end else begin
      full <= nxt_full;
      req  <= nxt_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto a single memory port with
// back-to-back grants and a sticky protocol-violation flag.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter bit D_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err
);

  arb_state_t                state, state_nxt;
  mem_req_t                  mem_q;
  mem_req_t [NUM_REQ-1:0]    pulse_req, nxt_req;
  logic     [NUM_REQ-1:0]    pulse, clr, nxt_full, drop;
  logic                      d_both;

  assign pulse[REQ_I] = |imem_rmask;
  assign pulse[REQ_D] = (|dmem_rmask) || (|dmem_wmask);
  assign d_both       = (|dmem_rmask) && (|dmem_wmask);

  assign pulse_req[REQ_I] = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  // A read+write pulse is demoted to a pure write.
  assign pulse_req[REQ_D] = '{addr: dmem_addr, rmask: (|dmem_wmask) ? 4'h0 : dmem_rmask,
                              wmask: dmem_wmask, wdata: dmem_wdata};

  assign clr[REQ_I] = (state == SERVE_I) && mem_resp;
  assign clr[REQ_D] = (state == SERVE_D) && mem_resp;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    req_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .pulse     (pulse[g]),
      .pulse_req (pulse_req[g]),
      .clr       (clr[g]),
      .nxt_full  (nxt_full[g]),
      .nxt_req   (nxt_req[g]),
      .drop      (drop[g])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (nxt_full[REQ_D] && (D_PRIO || !nxt_full[REQ_I])) state_nxt = SERVE_D;
        else if (nxt_full[REQ_I])                             state_nxt = SERVE_I;
      end
      SERVE_I: if (mem_resp) state_nxt = nxt_full[REQ_D] ? SERVE_D : IDLE;
      SERVE_D: if (mem_resp) state_nxt = nxt_full[REQ_I] ? SERVE_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port register is only reloaded on a grant change, so it holds
  // steady for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mem_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        case (state_nxt)
          SERVE_I: mem_q <= nxt_req[REQ_I];
          SERVE_D: mem_q <= nxt_req[REQ_D];
          default: mem_q <= '0;
        endcase
      end
      if ((|drop) || d_both) err <= 1'b1;
    end
  end

  assign mem_addr  = mem_q.addr;
  assign mem_rmask = mem_q.rmask;
  assign mem_wmask = mem_q.wmask;
  assign mem_wdata = mem_q.wdata;

  assign imem_resp  = clr[REQ_I];
  assign dmem_resp  = clr[REQ_D];
  assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = (dmem_resp && (|mem_q.rmask)) ? mem_rdata : 32'h0;

endmodule
